// File: rtl/btn_event_pkg.sv
// Shared event encodings and pending-slot type for the button event arbiter.
package btn_event_pkg;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_RELEASE = 2'd1,
        EVT_LONG    = 2'd2,
        EVT_RSVD    = 2'd3
    } evt_type_e;

    typedef struct packed {
        logic      valid;
        evt_type_e etype;
    } pend_slot_t;

endpackage

// File: rtl/btn_event_detect.sv
// Per-channel edge detector with a one-deep pending event slot.
// Long-press counter is built only when BTN_LONG_PRESS_EN is defined.
module btn_event_detect
    import btn_event_pkg::*;
#(
    parameter int LONG_PRESS_CYCLES = 50_000_000
) (
    input  logic       clk_fast,
    input  logic       reset,
    input  logic       btn_level,
    input  logic       grant,
    output pend_slot_t slot,
    output logic       overflow_set
);

    logic prev_level;
    logic press_edge;
    logic release_edge;
    logic long_hit;
    logic new_event;

    // Buttons are active-low, so idle level is 1
    assign press_edge   = prev_level & ~btn_level;
    assign release_edge = ~prev_level & btn_level;

    always_ff @(posedge clk_fast) begin
        if (reset) begin
            prev_level <= 1'b1;
        end else begin
            prev_level <= btn_level;
        end
    end

`ifdef BTN_LONG_PRESS_EN
    localparam int CNT_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(LONG_PRESS_CYCLES);
    localparam logic [CNT_W-1:0] LONG_HIT_AT = CNT_W'(LONG_PRESS_CYCLES - 1);

    logic [CNT_W-1:0] hold_cnt;

    always_ff @(posedge clk_fast) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (press_edge || release_edge) begin
            hold_cnt <= '0;
        end else if (!btn_level && hold_cnt != CNT_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    // Fires once, on the increment that reaches the threshold; saturation stops repeats
    assign long_hit = !btn_level && !press_edge && (hold_cnt == LONG_HIT_AT);
`else
    assign long_hit = 1'b0;
`endif

    assign new_event    = press_edge | release_edge | long_hit;
    assign overflow_set = new_event & slot.valid & ~grant;

    // A new event always wins over the grant-clear, so nothing is lost when both coincide
    always_ff @(posedge clk_fast) begin
        if (reset) begin
            slot <= '{valid: 1'b0, etype: EVT_PRESS};
        end else if (press_edge) begin
            slot <= '{valid: 1'b1, etype: EVT_PRESS};
        end else if (release_edge) begin
            slot <= '{valid: 1'b1, etype: EVT_RELEASE};
        end else if (long_hit) begin
            slot <= '{valid: 1'b1, etype: EVT_LONG};
        end else if (grant) begin
            slot.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/button_event_arbiter.sv
// Round-robin arbiter merging per-button events into a first-word-fall-through FIFO.
// Optional long-press events are enabled with the BTN_LONG_PRESS_EN macro.
module button_event_arbiter
    import btn_event_pkg::*;
#(
    parameter int NUM_BTNS          = 4,
    parameter int FIFO_DEPTH        = 4,
    parameter int LONG_PRESS_CYCLES = 50_000_000
) (
    input  logic                          clk_fast,
    input  logic                          reset,
    input  logic [NUM_BTNS-1:0]           btn_debounced_in,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [$clog2(NUM_BTNS)-1:0]   evt_btn_id,
    output logic [1:0]                    evt_type,
    output logic                          evt_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count
);

    localparam int ID_W  = $clog2(NUM_BTNS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ID_W-1:0] id;
        evt_type_e       etype;
    } fifo_entry_t;

    pend_slot_t           slots [NUM_BTNS];
    logic [NUM_BTNS-1:0]  pend_valid;
    logic [NUM_BTNS-1:0]  grant;
    logic [NUM_BTNS-1:0]  ovf_set;

    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      arb_idx;
    logic [ID_W:0]        idx_sum;
    logic                 arb_found;
    logic                 push_ok;
    logic                 do_push;
    logic                 pop;

    fifo_entry_t          fifo_mem [FIFO_DEPTH];
    fifo_entry_t          head;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_chan
        btn_event_detect #(
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
        ) u_detect (
            .clk_fast    (clk_fast),
            .reset       (reset),
            .btn_level   (btn_debounced_in[g]),
            .grant       (grant[g]),
            .slot        (slots[g]),
            .overflow_set(ovf_set[g])
        );
        assign pend_valid[g] = slots[g].valid;
    end

    // Search from rr_ptr upward with wrap; NUM_BTNS need not be a power of two
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        idx_sum   = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            idx_sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (idx_sum >= (ID_W+1)'(NUM_BTNS)) begin
                idx_sum = idx_sum - (ID_W+1)'(NUM_BTNS);
            end
            if (!arb_found && pend_valid[idx_sum[ID_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = idx_sum[ID_W-1:0];
            end
        end
    end

    assign evt_valid = (evt_count != '0);
    assign pop       = evt_valid & evt_ready;
    assign push_ok   = (evt_count < CNT_W'(FIFO_DEPTH)) | pop;
    assign do_push   = arb_found & push_ok;

    always_comb begin
        grant = '0;
        if (do_push) begin
            grant[arb_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_fast) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (do_push) begin
            if (arb_idx == ID_W'(NUM_BTNS - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= arb_idx + 1'b1;
            end
        end
    end

    // Storage needs no reset; occupancy and pointers define what is valid
    always_ff @(posedge clk_fast) begin
        if (do_push) begin
            fifo_mem[wr_ptr] <= '{id: arb_idx, etype: slots[arb_idx].etype};
        end
    end

    always_ff @(posedge clk_fast) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            evt_count <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, pop})
                2'b10:   evt_count <= evt_count + 1'b1;
                2'b01:   evt_count <= evt_count - 1'b1;
                default: evt_count <= evt_count;
            endcase
        end
    end

    always_ff @(posedge clk_fast) begin
        if (reset) begin
            evt_overflow <= 1'b0;
        end else if (|ovf_set) begin
            evt_overflow <= 1'b1;
        end
    end

    assign head       = fifo_mem[rd_ptr];
    assign evt_btn_id = head.id;
    assign evt_type   = head.etype;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Scoreboard bench for button_event_arbiter (6 channels, 4-deep FIFO, 20-cycle long press).
module tb_button_event_arbiter;
    import btn_event_pkg::*;

    localparam int NUM_BTNS   = 6;
    localparam int FIFO_DEPTH = 4;
    localparam int LONG_CYC   = 20;
    localparam int ID_W       = $clog2(NUM_BTNS);
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

    logic                clk_fast = 1'b0;
    logic                reset;
    logic [NUM_BTNS-1:0] btn;
    logic                evt_valid;
    logic                evt_ready;
    logic [ID_W-1:0]     evt_btn_id;
    logic [1:0]          evt_type;
    logic                evt_overflow;
    logic [CNT_W-1:0]    evt_count;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [1:0]      etype;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    button_event_arbiter #(
        .NUM_BTNS         (NUM_BTNS),
        .FIFO_DEPTH       (FIFO_DEPTH),
        .LONG_PRESS_CYCLES(LONG_CYC)
    ) dut (
        .clk_fast        (clk_fast),
        .reset           (reset),
        .btn_debounced_in(btn),
        .evt_valid       (evt_valid),
        .evt_ready       (evt_ready),
        .evt_btn_id      (evt_btn_id),
        .evt_type        (evt_type),
        .evt_overflow    (evt_overflow),
        .evt_count       (evt_count)
    );

    always #5 clk_fast = ~clk_fast;

    // Every accepted head event is popped against the expected queue
    always @(negedge clk_fast) begin
        if (!reset && evt_valid && evt_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_event: got id=%0d type=%0d, required no event", evt_btn_id, evt_type);
            end else begin
                mon_e = exp_q.pop_front();
                if (evt_btn_id !== mon_e.id || evt_type !== mon_e.etype) begin
                    failures++;
                    $display("[TB] FAIL event_order: got id=%0d type=%0d, required id=%0d type=%0d",
                             evt_btn_id, evt_type, mon_e.id, mon_e.etype);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_fast);
        #1;
    endtask

    task automatic expect_evt(input int id, input evt_type_e t);
        exp_t e;
        e.id    = ID_W'(id);
        e.etype = t;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        exp_q.delete();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        btn       = '1;
        evt_ready = 1'b1;
        tick(3);
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %0b, required 0", evt_valid); end
        checks++; if (evt_count !== '0) begin failures++; $display("[TB] FAIL reset_count: got %0d, required 0", evt_count); end
        checks++; if (evt_overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow: got %0b, required 0", evt_overflow); end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_single_press();
        btn[1] = 1'b0;
        expect_evt(1, EVT_PRESS);
        tick(1);
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("[TB] FAIL latency_early: got valid=%0b, required 0", evt_valid); end
        tick(1);
        checks++; if (evt_valid !== 1'b1) begin failures++; $display("[TB] FAIL latency_valid: got valid=%0b, required 1", evt_valid); end
        checks++; if (evt_count !== CNT_W'(1)) begin failures++; $display("[TB] FAIL latency_count: got %0d, required 1", evt_count); end
        tick(1);
        checks++; if (evt_count !== '0) begin failures++; $display("[TB] FAIL single_drain: got %0d, required 0", evt_count); end
        btn[1] = 1'b1;
        expect_evt(1, EVT_RELEASE);
        tick(4);
        checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL single_pending: got %0d outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_round_robin();
        do_reset();
        btn[0] = 1'b0; btn[2] = 1'b0;
        expect_evt(0, EVT_PRESS); expect_evt(2, EVT_PRESS);
        tick(5);
        btn[2] = 1'b1;
        expect_evt(2, EVT_RELEASE);
        tick(4);
        btn[0] = 1'b1;
        expect_evt(0, EVT_RELEASE);
        tick(4);
        // pointer now sits at channel 1, so channel 2 wins the next tie
        btn[0] = 1'b0; btn[2] = 1'b0;
        expect_evt(2, EVT_PRESS); expect_evt(0, EVT_PRESS);
        tick(5);
        btn[0] = 1'b1; btn[2] = 1'b1;
        expect_evt(2, EVT_RELEASE); expect_evt(0, EVT_RELEASE);
        tick(5);
        checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL rr_pending: got %0d outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_fifo_full();
        do_reset();
        evt_ready = 1'b0;
        btn = 6'b100000;
        for (int i = 0; i < 5; i++) expect_evt(i, EVT_PRESS);
        tick(8);
        checks++; if (evt_count !== CNT_W'(4)) begin failures++; $display("[TB] FAIL full_count: got %0d, required 4", evt_count); end
        checks++; if (evt_overflow !== 1'b0) begin failures++; $display("[TB] FAIL full_no_ovf: got %0b, required 0", evt_overflow); end
        checks++; if (evt_btn_id !== ID_W'(0) || evt_type !== 2'd0) begin failures++; $display("[TB] FAIL full_head: got id=%0d type=%0d, required id=0 type=0", evt_btn_id, evt_type); end
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        checks++; if (evt_count !== CNT_W'(4)) begin failures++; $display("[TB] FAIL push_on_pop: got %0d, required 4", evt_count); end
        checks++; if (evt_btn_id !== ID_W'(1)) begin failures++; $display("[TB] FAIL head_advance: got id=%0d, required 1", evt_btn_id); end
        tick(3);
        checks++; if (evt_btn_id !== ID_W'(1) || evt_count !== CNT_W'(4)) begin failures++; $display("[TB] FAIL head_stable: got id=%0d count=%0d, required id=1 count=4", evt_btn_id, evt_count); end
        evt_ready = 1'b1;
        tick(8);
        checks++; if (evt_count !== '0) begin failures++; $display("[TB] FAIL full_drain: got %0d, required 0", evt_count); end
        btn = '1;
        for (int i = 0; i < 5; i++) expect_evt(i, EVT_RELEASE);
        tick(10);
        checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL full_pending: got %0d outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_overflow();
        do_reset();
        evt_ready = 1'b0;
        btn = 6'b101000;
        expect_evt(0, EVT_PRESS); expect_evt(1, EVT_PRESS);
        expect_evt(2, EVT_PRESS); expect_evt(4, EVT_PRESS);
        tick(6);
        checks++; if (evt_count !== CNT_W'(4)) begin failures++; $display("[TB] FAIL ovf_fill: got %0d, required 4", evt_count); end
        btn[3] = 1'b0;
        tick(1);
        checks++; if (evt_overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_early: got %0b, required 0", evt_overflow); end
        btn[3] = 1'b1;
        tick(1);
        checks++; if (evt_overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_set: got %0b, required 1", evt_overflow); end
        expect_evt(3, EVT_RELEASE);
        evt_ready = 1'b1;
        tick(8);
        checks++; if (evt_overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sticky: got %0b, required 1", evt_overflow); end
        btn = '1;
        expect_evt(4, EVT_RELEASE); expect_evt(0, EVT_RELEASE);
        expect_evt(1, EVT_RELEASE); expect_evt(2, EVT_RELEASE);
        tick(8);
        checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL ovf_pending: got %0d outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_stream();
        evt_ready = 1'b0;
        btn = 6'b111000;
        expect_evt(0, EVT_PRESS); expect_evt(1, EVT_PRESS); expect_evt(2, EVT_PRESS);
        tick(6);
        checks++; if (evt_count !== CNT_W'(3)) begin failures++; $display("[TB] FAIL mid_queued: got %0d, required 3", evt_count); end
        reset = 1'b1;
        tick(1);
        checks++; if (evt_valid !== 1'b0 || evt_count !== '0 || evt_overflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_reset: got valid=%0b count=%0d ovf=%0b, required 0 0 0", evt_valid, evt_count, evt_overflow);
        end
        exp_q.delete();
        tick(1);
        reset = 1'b0;
        expect_evt(0, EVT_PRESS); expect_evt(1, EVT_PRESS); expect_evt(2, EVT_PRESS);
        evt_ready = 1'b1;
        tick(8);
        btn = '1;
        expect_evt(0, EVT_RELEASE); expect_evt(1, EVT_RELEASE); expect_evt(2, EVT_RELEASE);
        tick(8);
        checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL held_press: got %0d outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_long_press();
        int exp_mid;
        do_reset();
        evt_ready = 1'b1;
        btn[0] = 1'b0;
        expect_evt(0, EVT_PRESS);
`ifdef BTN_LONG_PRESS_EN
        expect_evt(0, EVT_LONG);
        exp_mid = 1;
`else
        exp_mid = 0;
`endif
        tick(15);
        checks++; if (exp_q.size() != exp_mid) begin failures++; $display("[TB] FAIL long_early: got %0d outstanding, required %0d", exp_q.size(), exp_mid); end
        tick(10);
        checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL long_arrive: got %0d outstanding, required 0", exp_q.size()); end
        tick(25);
        btn[0] = 1'b1;
        expect_evt(0, EVT_RELEASE);
        tick(6);
        checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL long_release: got %0d outstanding, required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_round_robin();
        test_fifo_full();
        test_overflow();
        test_reset_mid_stream();
        test_long_press();
        tick(4);
        checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL final_queue: got %0d outstanding, required 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
